// File: rtl/sim_mem_arbiter.sv
// Two-host round-robin arbiter in front of a single-port, fixed-latency simulation memory.
// A latency-matched pipeline routes responses, answers blocked writes locally and checks memory rvalid.
module sim_mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LATENCY  = 1,
   parameter int WRITABLE = 0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            h0_req_i,
   output logic            h0_gnt_o,
   input  logic            h0_we_i,
   input  logic [DW/8-1:0] h0_be_i,
   input  logic [AW-1:0]   h0_addr_i,
   input  logic [DW-1:0]   h0_wdata_i,
   output logic            h0_rvalid_o,
   output logic [DW-1:0]   h0_rdata_o,
   output logic            h0_err_o,
   input  logic            h1_req_i,
   output logic            h1_gnt_o,
   input  logic            h1_we_i,
   input  logic [DW/8-1:0] h1_be_i,
   input  logic [AW-1:0]   h1_addr_i,
   input  logic [DW-1:0]   h1_wdata_i,
   output logic            h1_rvalid_o,
   output logic [DW-1:0]   h1_rdata_o,
   output logic            h1_err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic [DW-1:0]   mem_rdata_i,
   input  logic            mem_rvalid_i,
   output logic            proto_err_o
);

   localparam int BW = DW / 8;
   localparam logic [2:0] WarmDone = 3'(LATENCY);

   logic               lastGnt_q, lastGnt_d;
   logic [LATENCY-1:0] pipeValid_q, pipeValid_d;
   logic [LATENCY-1:0] pipeOwner_q, pipeOwner_d;
   logic [LATENCY-1:0] pipeLocal_q, pipeLocal_d;
   logic [2:0]         warmCnt_q, warmCnt_d;
   logic               protoErr_q, protoErr_d;

   logic               gnt0, gnt1, anyGnt, blocked, memReq;
   logic               selWe;
   logic [BW-1:0]      selBe;
   logic [AW-1:0]      selAddr;
   logic [DW-1:0]      selWdata;
   logic               tailValid, tailOwner, tailLocal, checkEn, expectRvalid;

   // lastGnt_q == 1 means host 1 was served last, so host 0 wins a tie.
   always_comb begin
      gnt0      = ~rst_i & h0_req_i & (~h1_req_i | lastGnt_q);
      gnt1      = ~rst_i & h1_req_i & (~h0_req_i | ~lastGnt_q);
      anyGnt    = gnt0 | gnt1;
      lastGnt_d = anyGnt ? gnt1 : lastGnt_q;
   end

   always_comb begin
      selWe    = gnt1 ? h1_we_i    : h0_we_i;
      selBe    = gnt1 ? h1_be_i    : h0_be_i;
      selAddr  = gnt1 ? h1_addr_i  : h0_addr_i;
      selWdata = gnt1 ? h1_wdata_i : h0_wdata_i;
      blocked  = anyGnt & selWe & (WRITABLE == 0);
      memReq   = anyGnt & ~blocked;
   end

   assign h0_gnt_o    = gnt0;
   assign h1_gnt_o    = gnt1;
   assign mem_req_o   = memReq;
   assign mem_we_o    = memReq ? selWe    : 1'b0;
   assign mem_be_o    = memReq ? selBe    : '0;
   assign mem_addr_o  = memReq ? selAddr  : '0;
   assign mem_wdata_o = memReq ? selWdata : '0;

   // Entry 0 is the newest; the tail entry answers in this cycle.
   always_comb begin
      pipeValid_d    = '0;
      pipeOwner_d    = '0;
      pipeLocal_d    = '0;
      pipeValid_d[0] = anyGnt;
      pipeOwner_d[0] = gnt1;
      pipeLocal_d[0] = blocked;
      for (int i = 1; i < LATENCY; i++) begin
         pipeValid_d[i] = pipeValid_q[i-1];
         pipeOwner_d[i] = pipeOwner_q[i-1];
         pipeLocal_d[i] = pipeLocal_q[i-1];
      end
   end

   always_comb begin
      tailValid = pipeValid_q[LATENCY-1] & ~rst_i;
      tailOwner = pipeOwner_q[LATENCY-1];
      tailLocal = pipeLocal_q[LATENCY-1];

      h0_rvalid_o = tailValid & ~tailOwner;
      h1_rvalid_o = tailValid & tailOwner;
      h0_err_o    = h0_rvalid_o & tailLocal;
      h1_err_o    = h1_rvalid_o & tailLocal;
      h0_rdata_o  = (h0_rvalid_o & ~tailLocal) ? mem_rdata_i : '0;
      h1_rdata_o  = (h1_rvalid_o & ~tailLocal) ? mem_rdata_i : '0;
   end

   // Responses to requests dropped by reset may still arrive; skip checking for LATENCY cycles.
   always_comb begin
      checkEn      = (warmCnt_q == WarmDone);
      expectRvalid = pipeValid_q[LATENCY-1] & ~pipeLocal_q[LATENCY-1];
      warmCnt_d    = checkEn ? warmCnt_q : warmCnt_q + 3'd1;
      protoErr_d   = protoErr_q | (checkEn & (mem_rvalid_i != expectRvalid));
   end

   assign proto_err_o = protoErr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lastGnt_q   <= 1'b1;
         pipeValid_q <= '0;
         pipeOwner_q <= '0;
         pipeLocal_q <= '0;
         warmCnt_q   <= '0;
         protoErr_q  <= 1'b0;
      end else begin
         lastGnt_q   <= lastGnt_d;
         pipeValid_q <= pipeValid_d;
         pipeOwner_q <= pipeOwner_d;
         pipeLocal_q <= pipeLocal_d;
         warmCnt_q   <= warmCnt_d;
         protoErr_q  <= protoErr_d;
      end
   end

endmodule

// File: tb/tb_sim_mem_arbiter.sv
// Bench for sim_mem_arbiter: two instances (LATENCY=1 read-only, LATENCY=3 writable) share host stimulus,
// each with its own memory model, and are compared every cycle against a transaction-level reference.
module tb_sim_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        h0Req = 0, h1Req = 0, h0We = 0, h1We = 0;
   logic [3:0]  h0Be = 0, h1Be = 0;
   logic [31:0] h0Addr = 0, h1Addr = 0, h0Wdata = 0, h1Wdata = 0;

   logic [1:0]  gnt0, gnt1, rv0, rv1, err0, err1, memReq, memWe, protoErr;
   logic [1:0]  memRv = '0;
   logic [3:0]  memBe [2];
   logic [31:0] rd0 [2];
   logic [31:0] rd1 [2];
   logic [31:0] memAddr [2];
   logic [31:0] memWdata [2];
   logic [31:0] memRdata [2];

   sim_mem_arbiter #(.AW(32), .DW(32), .LATENCY(1), .WRITABLE(0)) dutA (
      .clk_i(clk), .rst_i(rst),
      .h0_req_i(h0Req), .h0_gnt_o(gnt0[0]), .h0_we_i(h0We), .h0_be_i(h0Be), .h0_addr_i(h0Addr),
      .h0_wdata_i(h0Wdata), .h0_rvalid_o(rv0[0]), .h0_rdata_o(rd0[0]), .h0_err_o(err0[0]),
      .h1_req_i(h1Req), .h1_gnt_o(gnt1[0]), .h1_we_i(h1We), .h1_be_i(h1Be), .h1_addr_i(h1Addr),
      .h1_wdata_i(h1Wdata), .h1_rvalid_o(rv1[0]), .h1_rdata_o(rd1[0]), .h1_err_o(err1[0]),
      .mem_req_o(memReq[0]), .mem_we_o(memWe[0]), .mem_be_o(memBe[0]), .mem_addr_o(memAddr[0]),
      .mem_wdata_o(memWdata[0]), .mem_rdata_i(memRdata[0]), .mem_rvalid_i(memRv[0]),
      .proto_err_o(protoErr[0])
   );

   sim_mem_arbiter #(.AW(32), .DW(32), .LATENCY(3), .WRITABLE(1)) dutB (
      .clk_i(clk), .rst_i(rst),
      .h0_req_i(h0Req), .h0_gnt_o(gnt0[1]), .h0_we_i(h0We), .h0_be_i(h0Be), .h0_addr_i(h0Addr),
      .h0_wdata_i(h0Wdata), .h0_rvalid_o(rv0[1]), .h0_rdata_o(rd0[1]), .h0_err_o(err0[1]),
      .h1_req_i(h1Req), .h1_gnt_o(gnt1[1]), .h1_we_i(h1We), .h1_be_i(h1Be), .h1_addr_i(h1Addr),
      .h1_wdata_i(h1Wdata), .h1_rvalid_o(rv1[1]), .h1_rdata_o(rd1[1]), .h1_err_o(err1[1]),
      .mem_req_o(memReq[1]), .mem_we_o(memWe[1]), .mem_be_o(memBe[1]), .mem_addr_o(memAddr[1]),
      .mem_wdata_o(memWdata[1]), .mem_rdata_i(memRdata[1]), .mem_rvalid_i(memRv[1]),
      .proto_err_o(protoErr[1])
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int injCycle = -1;

   function automatic int latOf(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic bit wrOf(int d);
      return d == 1;
   endfunction

   function automatic logic [31:0] memData(logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory models: answer every accepted request exactly LATENCY cycles later, garbage data otherwise.
   typedef struct {int due; logic [31:0] addr;} memRsp_t;
   memRsp_t memQ [2][$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (memQ[d].size() > 0 && memQ[d][0].due == cyc) begin
            memRv[d]    = 1'b1;
            memRdata[d] = memData(memQ[d][0].addr);
            void'(memQ[d].pop_front());
         end else begin
            memRv[d]    = (cyc == injCycle);
            memRdata[d] = $urandom;
         end
      end
   end

   // Reference: list of outstanding transactions per instance, each due at grant cycle + LATENCY.
   typedef struct {int due; int owner; bit isLocal; logic [31:0] addr;} expRsp_t;
   expRsp_t expQ [2][$];
   int      refLast = 1;
   bit      expProto [2] = '{1'b0, 1'b0};
   int      age [2] = '{0, 0};

   always @(negedge clk) begin : compare
      logic        eg0, eg1, anyG, selWe, eMemReq, hasRsp, memExp, eRv0, eRv1;
      logic [3:0]  selBe;
      logic [31:0] selAddr, selWdata, eData;
      expRsp_t     r;
      int          L;
      if (rst) begin
         eg0 = 1'b0;
         eg1 = 1'b0;
      end else begin
         eg0 = h0Req && (!h1Req || refLast == 1);
         eg1 = h1Req && (!h0Req || refLast == 0);
      end
      anyG     = eg0 | eg1;
      selWe    = eg1 ? h1We    : h0We;
      selBe    = eg1 ? h1Be    : h0Be;
      selAddr  = eg1 ? h1Addr  : h0Addr;
      selWdata = eg1 ? h1Wdata : h0Wdata;
      for (int d = 0; d < 2; d++) begin
         L = latOf(d);
         checkOutput($sformatf("dut%0d.h0_gnt", d), gnt0[d], eg0);
         checkOutput($sformatf("dut%0d.h1_gnt", d), gnt1[d], eg1);
         eMemReq = anyG && (!selWe || wrOf(d));
         checkOutput($sformatf("dut%0d.mem_req", d), memReq[d], eMemReq);
         checkOutput($sformatf("dut%0d.mem_we", d), memWe[d], eMemReq ? selWe : 1'b0);
         checkOutput($sformatf("dut%0d.mem_be", d), memBe[d], eMemReq ? selBe : 4'h0);
         checkOutput($sformatf("dut%0d.mem_addr", d), memAddr[d], eMemReq ? selAddr : 32'h0);
         checkOutput($sformatf("dut%0d.mem_wdata", d), memWdata[d], eMemReq ? selWdata : 32'h0);

         r = '{0, 0, 1'b0, 32'h0};
         hasRsp = !rst && expQ[d].size() > 0 && expQ[d][0].due == cyc;
         if (hasRsp) r = expQ[d][0];
         memExp = hasRsp && !r.isLocal;
         eRv0   = hasRsp && r.owner == 0;
         eRv1   = hasRsp && r.owner == 1;
         eData  = memExp ? memData(r.addr) : 32'h0;
         checkOutput($sformatf("dut%0d.h0_rvalid", d), rv0[d], eRv0);
         checkOutput($sformatf("dut%0d.h1_rvalid", d), rv1[d], eRv1);
         checkOutput($sformatf("dut%0d.h0_err", d), err0[d], eRv0 && r.isLocal);
         checkOutput($sformatf("dut%0d.h1_err", d), err1[d], eRv1 && r.isLocal);
         checkOutput($sformatf("dut%0d.h0_rdata", d), rd0[d], eRv0 ? eData : 32'h0);
         checkOutput($sformatf("dut%0d.h1_rdata", d), rd1[d], eRv1 ? eData : 32'h0);
         if (!rst) checkOutput($sformatf("dut%0d.proto_err", d), protoErr[d], expProto[d]);

         if (rst) begin
            expQ[d].delete();
            age[d]      = 0;
            expProto[d] = 1'b0;
         end else begin
            if (age[d] >= L && memRv[d] != memExp) expProto[d] = 1'b1;
            if (hasRsp) void'(expQ[d].pop_front());
            if (anyG) expQ[d].push_back('{cyc + L, eg1 ? 1 : 0, selWe && !wrOf(d), selAddr});
            if (age[d] < L) age[d]++;
         end
         if (memReq[d]) memQ[d].push_back('{cyc + L, memAddr[d]});
      end
      if (rst) refLast = 1;
      else if (anyG) refLast = eg1 ? 1 : 0;
   end

   // Hosts hold an ungranted request and its fields stable until granted.
   bit stall [2] = '{1'b0, 1'b0};

   task automatic applyStimulus(input bit r0, input bit r1, input bit w0, input bit w1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (!stall[0]) begin
         h0Req = r0; h0We = w0; h0Addr = a0; h0Wdata = d0; h0Be = 4'($urandom);
      end
      if (!stall[1]) begin
         h1Req = r1; h1We = w1; h1Addr = a1; h1Wdata = d1; h1Be = 4'($urandom);
      end
      @(negedge clk);
      stall[0] = h0Req && !gnt0[0];
      stall[1] = h1Req && !gnt1[0];
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      h0Req = 1'b0;
      h1Req = 1'b0;
      stall = '{1'b0, 1'b0};
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] g;
      int cnt0, cnt1;

      doReset(2);

      // Single host read at 0x10.
      applyStimulus(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0);
      checkOutput("single.h0_gnt", gnt0[0], 1);
      checkOutput("single.mem_addr", memAddr[0], 32'h10);
      idle(1);
      checkOutput("single.l1_rvalid", rv0[0], 1);
      checkOutput("single.l1_rdata", rd0[0], 32'hDEADBEEF);
      checkOutput("single.l1_err", err0[0], 0);
      checkOutput("single.l1_h1_rvalid", rv1[0], 0);
      idle(2);
      checkOutput("single.l3_rvalid", rv0[1], 1);
      checkOutput("single.l3_rdata", rd0[1], 32'hDEADBEEF);

      // Contention right after reset: strict alternation starting with host 0.
      doReset(1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1, 1, 0, 0, 32'h100 + 32'(k * 4), 32'h200 + 32'(k * 4), 32'h0, 32'h0);
         g = gnt1[0] ? 32'd1 : (gnt0[0] ? 32'd0 : 32'hFFFFFFFF);
         checkOutput($sformatf("contend.grant%0d", k), g, 32'(k % 2));
      end
      idle(5);

      // Blocked write from host 1.
      applyStimulus(0, 1, 0, 1, 32'h0, 32'h20, 32'h0, 32'h55);
      checkOutput("bwrite.h1_gnt", gnt1[0], 1);
      checkOutput("bwrite.ro_mem_req", memReq[0], 0);
      checkOutput("bwrite.rw_mem_req", memReq[1], 1);
      checkOutput("bwrite.rw_wdata", memWdata[1], 32'h55);
      idle(1);
      checkOutput("bwrite.h1_rvalid", rv1[0], 1);
      checkOutput("bwrite.h1_err", err1[0], 1);
      checkOutput("bwrite.h1_rdata", rd1[0], 0);
      checkOutput("bwrite.proto_err", protoErr[0], 0);
      idle(4);

      // Back-to-back reads alternating hosts; count every response.
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 13; k++) begin
         if (k < 10)
            applyStimulus(k % 2 == 0, k % 2 == 1, 0, 0, 32'h300 + 32'(k * 4), 32'h300 + 32'(k * 4),
                          32'h0, 32'h0);
         else
            idle(1);
         cnt0 += int'(rv0[0]) + int'(rv1[0]);
         cnt1 += int'(rv0[1]) + int'(rv1[1]);
      end
      checkOutput("sweep.l1_count", cnt0, 10);
      checkOutput("sweep.l3_count", cnt1, 10);
      idle(4);

      // Reset while two reads are in flight.
      applyStimulus(1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h34, 32'h0, 32'h0);
      doReset(1);
      applyStimulus(1, 1, 0, 0, 32'h40, 32'h44, 32'h0, 32'h0);
      checkOutput("midrst.h0_first", gnt0[1], 1);
      checkOutput("midrst.h1_waits", gnt1[1], 0);
      idle(6);
      checkOutput("midrst.l1_proto", protoErr[0], 0);
      checkOutput("midrst.l3_proto", protoErr[1], 0);

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) == 0) doReset(1);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                       {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                       $urandom, $urandom);
      end
      idle(6);

      // Unexpected memory rvalid while the pipeline is empty.
      injCycle = cyc + 1;
      idle(1);
      checkOutput("proto.before", protoErr[0], 0);
      idle(1);
      checkOutput("proto.l1_set", protoErr[0], 1);
      checkOutput("proto.l3_set", protoErr[1], 1);
      idle(3);
      checkOutput("proto.sticky", protoErr[0], 1);
      doReset(1);
      idle(1);
      checkOutput("proto.cleared", protoErr[0], 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sim_mem_arbiter.md
# sim_mem_arbiter

Two-host round-robin arbiter that shares one single-port, fixed-latency simulation memory between two Ibex-style hosts. The typical hosts are the core instruction-fetch and data ports, and the memory is a sim ROM/RAM. The block grants at most one request per cycle and tracks every issued transaction in a latency-matched pipeline. It uses that pipeline to route each response back to the correct host, to answer writes to read-only memory locally with an error, and to flag protocol mismatches from the memory.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 bits
- LATENCY, 1, memory read latency in cycles, from request cycle to rvalid (range 1–4)
- WRITABLE, 0, 1 = forward writes to memory; 0 = block writes and answer them with an error

Ports (N ∈ {0,1}; one identical set per host):
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset; reset is synchronous and active-high
- hN_req_i  in  1  host request
- hN_gnt_o  out  1  grant; combinational, same cycle as request
- hN_we_i  in  1  write enable
- hN_be_i  in  DW/8  byte enables
- hN_addr_i  in  AW  byte address
- hN_wdata_i  in  DW  write data
- hN_rvalid_o  out  1  response valid
- hN_rdata_o  out  DW  read data; 0 when hN_rvalid_o=0
- hN_err_o  out  1  error; valid with hN_rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DW/8  memory byte enables
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data
- mem_rvalid_i  in  1  memory response valid
- proto_err_o  out  1  sticky flag: memory rvalid did not match the expected response

## Operation
Arbitration:
- State register `last` holds the most recently granted host.
- Only one host requesting: that host is granted.
- Both hosts requesting: the host ≠ `last` is granted.
- `last` is updated only in cycles where a grant is issued.
- At most one of h0_gnt_o and h1_gnt_o is high in any cycle. A gnt is never high without the corresponding req.

Issue (granted cycle):
- Read, or write with WRITABLE=1: mem_req_o=1, and the granted host's we/be/addr/wdata are muxed onto mem_*.
- Write with WRITABLE=0: the host is granted but mem_req_o=0. The transaction is marked "local".
- mem_* data outputs carry the granted host's fields. They are don't-care (driven 0) when mem_req_o=0.

Response pipeline:
- A LATENCY-deep shift register, advanced every cycle. Each entry is {valid, owner, local}.
- The entry pushed in a granted cycle is {1, granted host, blocked-write}. In cycles with no grant, an empty entry is pushed.
- Tail entry valid → owner's hN_rvalid_o=1.
  - rdata = mem_rdata_i, or 0 if local.
  - err = local.
- The other host's rvalid/err/rdata outputs stay 0.

Protocol check:
- Let expected = tail.valid & ~tail.local.
- If mem_rvalid_i ≠ expected in any cycle out of reset, proto_err_o is set to 1. It is cleared only by reset.

## Timing
- Reset (rst_i=1 at posedge):
  - Pipeline cleared.
  - `last`=1, so host 0 wins the first contention.
  - proto_err_o=0.
  - All hN_rvalid_o/hN_err_o=0, hN_rdata_o=0.
- gnt is combinational and is held low while rst_i=1.
- Reset mid-operation: in-flight transactions are dropped and no rvalid is produced for them. Memory responses that arrive after reset is released are not checked until the first full LATENCY cycles have elapsed.
- Response latency: exactly LATENCY cycles after the grant cycle (grant at edge t → rvalid high during cycle t+LATENCY). This holds for both memory and local responses.
- Throughput: one grant per cycle, back-to-back. Responses return in grant order.
- Simultaneous events: a new grant and a tail response in the same cycle are independent. A host may receive rvalid in the same cycle as its own next gnt.
- A host holding req with no grant must keep addr/we/be/wdata stable; the arbiter does not latch request fields.

## Test plan
- Single host read: LATENCY=1. h0 reads 0x10 while the memory returns 0xDEADBEEF. Required: h0_gnt_o same cycle, mem_addr_o=0x10, h0_rvalid_o one cycle later with rdata 0xDEADBEEF, err=0. h1 outputs stay 0.
- Contention fairness: both hosts hold req for 6 cycles right after reset. Required: grant order h0,h1,h0,h1,h0,h1. Responses are routed in the same order with correct data per address.
- Blocked write: WRITABLE=0. h1 writes 0x55 to 0x20. Required: h1_gnt_o=1, mem_req_o=0. After LATENCY cycles h1_rvalid_o=1, h1_err_o=1, rdata=0, and proto_err_o stays 0.
- Latency sweep: LATENCY=3, back-to-back reads alternating hosts for 10 cycles. Required: every response arrives exactly 3 cycles after its grant, one per cycle, with no loss.
- Reset mid-flight: assert rst_i for 1 cycle while 2 reads are in flight. Required: no rvalid for the dropped reads, `last`=1 (h0 wins the next contention), proto_err_o=0.
- Protocol error: inject mem_rvalid_i=1 in a cycle whose tail entry is empty. Required: proto_err_o=1 from the next cycle until reset.
